// File: rtl/sp_sram.sv
// sp_sram: single-port synchronous SRAM behind one bidirectional data bus.
//
// Purpose
//   Generic on-chip storage macro. A write samples the shared data bus on the
//   rising edge. A read loads a registered output word. That word is driven
//   back onto the same bus while output is enabled.
//
// Parameters
//   ADDR_WIDTH  address bus width in bits
//   DATA_WIDTH  word width in bits, and also the data bus width
//   DEPTH       number of stored words, must be <= 2**ADDR_WIDTH
//
// Ports
//   clk   in     rising-edge clock
//   rst   in     synchronous active-high reset, clears only the read register
//   addr  in     word address
//   data  inout  write data in, read data out, high-Z otherwise
//   cs    in     chip select, active-high
//   we    in     write enable, 1 = write, 0 = read
//   oe    in     output enable, allows the block to drive data
module sp_sram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);

  // One extra bit so that DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DepthLimit = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_in_range;
  logic w_wr_en;
  logic w_rd_en;
  logic w_drive;

  always_comb begin
    w_in_range = ({1'b0, addr} < DepthLimit);
    // Reset suppresses any access in the same cycle.
    w_wr_en    = ~rst & cs & we & w_in_range;
    w_rd_en    = ~rst & cs & ~we;
    // Never drive while we=1, so the external writer owns the bus.
    w_drive    = cs & oe & ~we;
  end

  // Storage has no reset, so it maps onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[addr] <= data;
    end
  end

  // The read register holds its value until the next read or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_en) begin
      r_rdata <= w_in_range ? r_mem[addr] : '0;
    end
  end

  assign data = w_drive ? r_rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_sram.sv
// tb_sp_sram: directed self-checking bench for sp_sram.
// DEPTH is set below 2**ADDR_WIDTH so that out-of-range addresses exist.
// When the DUT must be high-Z, the bench parks the bus at zero. Any DUT drive
// of a nonzero held word then shows up as a changed bus value.
module tb_sp_sram;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1000;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic          cs;
  logic          we;
  logic          oe;
  logic [DW-1:0] bus_drv;
  logic          bus_en;
  wire  [DW-1:0] data;

  int n_checks;
  int n_pass;

  assign data = bus_en ? bus_drv : {DW{1'bz}};

  sp_sram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .addr(addr),
    .data(data),
    .cs  (cs),
    .we  (we),
    .oe  (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int i);
    return i * 32'h0101_0101 + 32'h0000_00A5;
  endfunction

  // Stimulus helpers. Each one ends 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cs = 1'b1; we = 1'b1; oe = 1'b0; addr = a;
    bus_en = 1'b1; bus_drv = d;
    tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    cs = 1'b1; we = 1'b0; oe = 1'b1; addr = a;
    bus_en = 1'b0;
    tick();
  endtask

  task automatic park();
    cs = 1'b0; we = 1'b0; oe = 1'b0;
    bus_en = 1'b1; bus_drv = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; we = 1'b0; oe = 1'b1; addr = '0; bus_en = 1'b0;
    tick();
    tick();
    n_checks++;
    if (data !== 32'h0000_0000)
      $display("FAIL reset_bus: got %h expected %h", data, 32'h0);
    else n_pass++;
    rst = 1'b0;
    park();
  endtask

  task automatic test_write_readback();
    for (int i = 0; i < 16; i++) do_write(i[AW-1:0], pat(i));
    for (int i = 0; i < 16; i++) begin
      do_read(i[AW-1:0]);
      n_checks++;
      if (data !== pat(i))
        $display("FAIL readback[%0d]: got %h expected %h", i, data, pat(i));
      else n_pass++;
    end
    do_read(10'd3);
    n_checks++;
    if (data !== 32'h0303_03A8)
      $display("FAIL readback_mem3: got %h expected %h", data, 32'h0303_03A8);
    else n_pass++;
    park();
  endtask

  // Only combinational changes between edges here, so no access occurs.
  task automatic test_tristate();
    // The read register now holds 0x030303A8, from the previous test.
    cs = 1'b0; we = 1'b0; oe = 1'b1; bus_en = 1'b1; bus_drv = '0; #1;
    n_checks++;
    if (data !== 32'h0) $display("FAIL z_cs0: got %h expected %h", data, 32'h0);
    else n_pass++;
    cs = 1'b1; we = 1'b0; oe = 1'b0; #1;
    n_checks++;
    if (data !== 32'h0) $display("FAIL z_oe0: got %h expected %h", data, 32'h0);
    else n_pass++;
    cs = 1'b1; we = 1'b1; oe = 1'b1; #1;
    n_checks++;
    if (data !== 32'h0) $display("FAIL z_we1: got %h expected %h", data, 32'h0);
    else n_pass++;
    cs = 1'b1; we = 1'b0; oe = 1'b1; bus_en = 1'b0; #1;
    n_checks++;
    if (data !== 32'h0303_03A8)
      $display("FAIL drive_on: got %h expected %h", data, 32'h0303_03A8);
    else n_pass++;
    park();
    tick();
  endtask

  task automatic test_hold_deselect();
    do_read(10'd5);
    n_checks++;
    if (data !== 32'h0505_05AA)
      $display("FAIL hold_read5: got %h expected %h", data, 32'h0505_05AA);
    else n_pass++;
    park();
    oe = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (data !== 32'h0) $display("FAIL deselect_z[%0d]: got %h expected %h", k, data, 32'h0);
      else n_pass++;
    end
    // Reselect without a read edge: the held word comes back.
    cs = 1'b1; we = 1'b0; oe = 1'b1; addr = 10'd9; bus_en = 1'b0; #1;
    n_checks++;
    if (data !== 32'h0505_05AA)
      $display("FAIL hold_reselect: got %h expected %h", data, 32'h0505_05AA);
    else n_pass++;
    // A write with cs=0 must not land.
    cs = 1'b0; we = 1'b1; oe = 1'b0; addr = 10'd5; bus_en = 1'b1; bus_drv = 32'h1234_5678;
    tick();
    do_read(10'd5);
    n_checks++;
    if (data !== 32'h0505_05AA)
      $display("FAIL cs0_write: got %h expected %h", data, 32'h0505_05AA);
    else n_pass++;
    park();
  endtask

  task automatic test_back_to_back();
    do_read(10'd2);
    do_write(10'd7, 32'h7777_0001);
    // The write left the read register alone.
    cs = 1'b1; we = 1'b0; oe = 1'b1; bus_en = 1'b0; #1;
    n_checks++;
    if (data !== 32'h0202_02A7)
      $display("FAIL write_keeps_rdata: got %h expected %h", data, 32'h0202_02A7);
    else n_pass++;
    do_read(10'd7);
    n_checks++;
    if (data !== 32'h7777_0001)
      $display("FAIL raw_next_cycle: got %h expected %h", data, 32'h7777_0001);
    else n_pass++;
    park();
  endtask

  task automatic test_boundary();
    do_write(10'd999, 32'hDEAD_BEEF);
    do_write(10'd1000, 32'hCAFE_F00D);
    do_write(10'd1023, 32'h5555_AAAA);
    do_read(10'd999);
    n_checks++;
    if (data !== 32'hDEAD_BEEF)
      $display("FAIL last_word: got %h expected %h", data, 32'hDEAD_BEEF);
    else n_pass++;
    do_read(10'd1000);
    n_checks++;
    if (data !== 32'h0) $display("FAIL oor_read_1000: got %h expected %h", data, 32'h0);
    else n_pass++;
    do_read(10'd0);
    n_checks++;
    if (data !== 32'h0000_00A5)
      $display("FAIL no_wrap_addr0: got %h expected %h", data, 32'h0000_00A5);
    else n_pass++;
    do_read(10'd1023);
    n_checks++;
    if (data !== 32'h0) $display("FAIL oor_read_1023: got %h expected %h", data, 32'h0);
    else n_pass++;
    park();
  endtask

  task automatic test_reset_mid();
    do_read(10'd999);
    n_checks++;
    if (data !== 32'hDEAD_BEEF)
      $display("FAIL pre_reset_read: got %h expected %h", data, 32'hDEAD_BEEF);
    else n_pass++;
    // Reset during a read: the read is suppressed and the register clears.
    rst = 1'b1;
    tick();
    n_checks++;
    if (data !== 32'h0) $display("FAIL mid_reset_bus: got %h expected %h", data, 32'h0);
    else n_pass++;
    // Reset during a write: the write is suppressed.
    do_write(10'd4, 32'h1111_1111);
    rst = 1'b0;
    do_read(10'd4);
    n_checks++;
    if (data !== 32'h0404_04A9)
      $display("FAIL reset_blocks_write: got %h expected %h", data, 32'h0404_04A9);
    else n_pass++;
    do_read(10'd999);
    n_checks++;
    if (data !== 32'hDEAD_BEEF)
      $display("FAIL mem_survives_reset: got %h expected %h", data, 32'hDEAD_BEEF);
    else n_pass++;
    park();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; addr = '0; cs = 1'b0; we = 1'b0; oe = 1'b0;
    bus_en = 1'b0; bus_drv = '0;
    #2;
    test_reset();
    test_write_readback();
    test_tristate();
    test_hold_deselect();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sp_sram.md
Name: sp_sram

Overview:
- Single-port synchronous SRAM with one bidirectional data bus, gated by chip-select (cs), write-enable (we) and output-enable (oe).
- Generic on-chip storage macro model used by bus-attached blocks and testbenches.
- Writes sample the shared data bus on the rising clock edge; reads return registered data onto the bus when output is enabled.

Parameters:
- ADDR_WIDTH, 10, address bus width in bits.
- DATA_WIDTH, 32, word width in bits; also the width of the data bus.
- DEPTH, 1024, number of words stored; must be <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  synchronous active-high reset.
- addr  input  ADDR_WIDTH  word address.
- data  inout  DATA_WIDTH  shared data bus: write data in, read data out, high-Z otherwise.
- cs  input  1  chip select, active-high.
- we  input  1  write enable, active-high; 1 = write, 0 = read.
- oe  input  1  output enable, active-high; allows the block to drive data.

Behaviour:
- Storage: array of DEPTH words of DATA_WIDTH bits.
  - Contents are not cleared by rst and are undefined (X) until written.
- Reset: at a posedge with rst=1, the read-data register clears to 0. Memory is untouched. Any write or read in that cycle is suppressed.
- Write: at a posedge with rst=0, cs=1, we=1:
  - mem[addr] <= data bus value.
  - The read register is unchanged.
  - Write latency: the word is readable by a read issued on the next cycle.
- Read: at a posedge with rst=0, cs=1, we=0:
  - rdata <= mem[addr].
  - Latency is 1 cycle: data for an address presented before edge N is valid after edge N.
  - rdata holds its value until the next read or reset.
- Bus drive: combinational. data = rdata when (cs & oe & ~we), else high-Z.
  - The block never drives the bus while we=1; this avoids contention with the external writer.
- cs=0: no write, no read-register update, bus high-Z regardless of we/oe.
- Out-of-range address (addr >= DEPTH):
  - Writes are ignored.
  - Reads load 0 into rdata.
- Read-after-write to the same address on consecutive cycles returns the newly written value. There is no same-cycle bypass, since read and write are mutually exclusive on one port.
- X/Z on the data bus during a write is stored as-is; no checking.
- Synthesis: infer a single-port RAM with registered output. The read register is the only resettable element.

Test Plan:
- Reset: drive rst=1 for 2 cycles with cs=1, we=0, oe=1 -> data bus reads 0x00000000. Then release rst.
- Write/readback:
  - Write pattern: mem[i] = i*0x01010101 + 0xA5, for i = 0..15, each with cs=1, we=1, oe=0 and the bench driving the bus.
  - Read back: cs=1, we=0, oe=1. Data for address i appears on the bus one cycle after addr=i is presented; mem[3] = 0x030303A8.
- Bus tri-state:
  - With cs=0, or oe=0, or we=1 -> the DUT leaves data at high-Z. Check that the bench's pull value is seen unchanged.
  - With cs=1, we=0, oe=1 -> the DUT drives.
- Hold and deselect:
  - Read addr 5, then deassert cs for 3 cycles -> bus is Z.
  - Reassert cs=1, oe=1, we=0 with no new read edge in between -> the bus shows the held mem[5] value.
  - Write with cs=0 to addr 5 -> mem[5] is unchanged on a later read.
- Boundary:
  - Write 0xDEADBEEF to addr DEPTH-1 -> read returns 0xDEADBEEF.
  - Write to addr DEPTH (if 2**ADDR_WIDTH > DEPTH) -> ignored; a read there returns 0. Address 0 is unaffected, so no wrap-around.
- Reset mid-operation:
  - After reading 0xDEADBEEF, assert rst for 1 cycle -> the bus shows 0.
  - A subsequent read of addr DEPTH-1 still returns 0xDEADBEEF, because memory contents survive reset.
